// File: rtl/xlate_pkg.sv
// Shared types for the VRAM tile snooper: window defaults, signature payload,
// snoop FSM state encoding and the per-byte signature step.
package xlate_pkg;

  localparam logic [15:0] TILE_BASE_DEF = 16'h8000;
  localparam logic [15:0] TILE_END_DEF  = 16'h97FF;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned TILE_IDX_W = 9;
  localparam int unsigned HASH_W     = 16;
  localparam int unsigned OFF_W      = 4;

  // One completed tile: its index and the 16-bit signature of its 16 bytes.
  typedef struct packed {
    logic [8:0]  tile_index;
    logic [15:0] hash;
  } tile_sig_t;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } snoop_state_e;

  // Rotate left by 5, then fold the data byte into the low bits.
  function automatic logic [15:0] hash_step(input logic [15:0] h, input logic [7:0] d);
    return {h[10:0], h[15:11]} ^ {8'h00, d};
  endfunction

endpackage

// File: rtl/vram_tile_snooper_if.sv
// CPU write bus snooped by the tile snooper plus the signature output stream.
//   bus_wr/bus_addr/bus_data : one-cycle VRAM write strobe, address, data
//   sig_valid/sig_ready      : signature stream handshake
//   sig_tile_index/sig_hash  : head-of-FIFO signature payload
interface vram_tile_snooper_if;
  import xlate_pkg::*;

  logic                  bus_wr;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_data;
  logic                  sig_valid;
  logic                  sig_ready;
  logic [TILE_IDX_W-1:0] sig_tile_index;
  logic [HASH_W-1:0]     sig_hash;

  modport master (
    output bus_wr, bus_addr, bus_data, sig_ready,
    input  sig_valid, sig_tile_index, sig_hash
  );

  modport slave (
    input  bus_wr, bus_addr, bus_data, sig_ready,
    output sig_valid, sig_tile_index, sig_hash
  );
endinterface

// File: rtl/tile_sig_fifo.sv
// Small signature FIFO. A push is accepted when not full, or when full and the
// head is popped in the same cycle; otherwise drop_c flags the lost entry.
//   push/push_data : write request and payload
//   ready          : consumer accepts head (pop when valid && ready)
//   valid/head     : head entry, held stable until popped
//   drop_c         : combinational, push refused this cycle
module tile_sig_fifo
  import xlate_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  tile_sig_t push_data,
  input  logic      ready,
  output logic      valid,
  output tile_sig_t head,
  output logic      drop_c
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  tile_sig_t         mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [CW-1:0]     count;
  logic              pop_c;
  logic              accept_c;

  assign valid    = (count != '0);
  assign head     = mem[rptr];
  assign pop_c    = valid && ready;
  assign accept_c = push && ((count < CW'(DEPTH)) || pop_c);
  assign drop_c   = push && !accept_c;

  // Storage and pointers; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (accept_c) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + PW'(1);
      end
      if (pop_c) rptr <= rptr + PW'(1);
      case ({accept_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vram_tile_snooper.sv
// Snoops CPU writes into the VRAM tile-data window, assembles each tile's 16
// bytes written in order, and queues a {tile index, signature} per completed
// tile for a downstream hash lookup.
//   clk, rst_n      : clock, async active-low reset
//   cfg_enable      : snooping enable (0 aborts assembly, FIFO keeps draining)
//   bus             : write bus in, signature stream out
//   cur_tile_index  : combinational tile index of this cycle's in-window write
//   cur_byte_offset : combinational byte offset of this cycle's in-window write
//   drop_cnt        : saturating count of tiles lost to a full FIFO
module vram_tile_snooper
  import xlate_pkg::*;
#(
  parameter logic [15:0] TILE_BASE      = TILE_BASE_DEF,
  parameter logic [15:0] TILE_END       = TILE_END_DEF,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_enable,
  vram_tile_snooper_if.slave    bus,
  output logic [TILE_IDX_W-1:0] cur_tile_index,
  output logic [OFF_W-1:0]      cur_byte_offset,
  output logic [7:0]            drop_cnt
);

  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);

  snoop_state_e          state_q, state_d;
  logic [TILE_IDX_W-1:0] tile_q, tile_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [HASH_W-1:0]     hash_q, hash_d;
  logic [IW-1:0]         idle_q, idle_d;

  logic                  in_win_c;
  logic [TILE_IDX_W-1:0] tile_c;
  logic [OFF_W-1:0]      off_c;
  logic                  start_c;
  logic                  push_c;
  tile_sig_t             push_data_c;
  tile_sig_t             head;
  logic                  drop_c;

  // Window decode of the current bus write.
  always_comb begin
    in_win_c        = bus.bus_wr && (bus.bus_addr >= TILE_BASE) && (bus.bus_addr <= TILE_END);
    tile_c          = TILE_IDX_W'((bus.bus_addr - TILE_BASE) >> 4);
    off_c           = bus.bus_addr[3:0];
    cur_tile_index  = in_win_c ? tile_c : '0;
    cur_byte_offset = in_win_c ? off_c : '0;
  end

  // Snoop FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tile_q  <= '0;
      off_q   <= '0;
      hash_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      off_q   <= off_d;
      hash_q  <= hash_d;
      idle_q  <= idle_d;
    end
  end

  // Snoop FSM next state. An offset-0 write always (re)starts a tile, since
  // the expected offset is never 0 while collecting.
  always_comb begin
    state_d     = state_q;
    tile_d      = tile_q;
    off_d       = off_q;
    hash_d      = hash_q;
    idle_d      = idle_q;
    start_c     = 1'b0;
    push_c      = 1'b0;
    push_data_c = '{tile_index: tile_q, hash: hash_step(hash_q, bus.bus_data)};

    if (!cfg_enable) begin
      state_d = IDLE;
      off_d   = '0;
      hash_d  = '0;
      idle_d  = '0;
    end else begin
      case (state_q)
        IDLE: start_c = in_win_c && (off_c == '0);
        COLLECT: begin
          if (in_win_c) begin
            idle_d = '0;
            if ((tile_c == tile_q) && (off_c == off_q)) begin
              hash_d = hash_step(hash_q, bus.bus_data);
              if (off_q == 4'hF) begin
                push_c  = 1'b1;
                state_d = IDLE;
                off_d   = '0;
              end else begin
                off_d = off_q + 4'd1;
              end
            end else if (off_c == '0) begin
              start_c = 1'b1;
            end else begin
              state_d = IDLE;
              off_d   = '0;
            end
          end else if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            off_d   = '0;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + IW'(1);
          end
        end
        default: state_d = IDLE;
      endcase

      if (start_c) begin
        state_d = COLLECT;
        tile_d  = tile_c;
        off_d   = 4'd1;
        hash_d  = hash_step(16'hFFFF, bus.bus_data);
        idle_d  = '0;
      end
    end
  end

  tile_sig_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (push_data_c),
    .ready     (bus.sig_ready),
    .valid     (bus.sig_valid),
    .head      (head),
    .drop_c    (drop_c)
  );

  assign bus.sig_tile_index = head.tile_index;
  assign bus.sig_hash       = head.hash;

  // Lost-tile counter, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt <= '0;
    else if (drop_c && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
  end

endmodule

// File: tb/tb_vram_tile_snooper.sv
// Self-checking bench for vram_tile_snooper: decode table, directed tile
// sequences and a randomized run compared against a queue-based model.
module tb_vram_tile_snooper;

  localparam int BASE    = 'h8000;
  localparam int LAST    = 'h97FF;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 1024;

  logic clk = 1'b0;
  logic rst_n;
  logic cfg_enable;
  logic [8:0] cur_tile_index;
  logic [3:0] cur_byte_offset;
  logic [7:0] drop_cnt;

  vram_tile_snooper_if bus ();

  vram_tile_snooper dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_enable      (cfg_enable),
    .bus             (bus),
    .cur_tile_index  (cur_tile_index),
    .cur_byte_offset (cur_byte_offset),
    .drop_cnt        (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [8:0]  t;
    logic [15:0] h;
  } ent_t;

  ent_t       q[$];
  int         m_drop;
  bit         m_active;
  int         m_tile, m_next, m_idle;
  logic [7:0] m_bytes [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Signature of a whole tile, folded from scratch over its 16 bytes.
  function automatic logic [15:0] ref_sig(input logic [7:0] b [16]);
    int h = 'hFFFF;
    for (int i = 0; i < 16; i++) h = (((h << 5) | (h >> 11)) & 'hFFFF) ^ int'(b[i]);
    return 16'(h);
  endfunction

  task automatic model_reset();
    q.delete();
    m_drop = 0; m_active = 0; m_tile = 0; m_next = 0; m_idle = 0;
  endtask

  // One clock of the reference behaviour.
  task automatic model_cycle(input bit wr, input logic [15:0] addr, input logic [7:0] data,
                             input bit en, input bit ready);
    bit   pop  = (q.size() != 0) && ready;
    bit   push = 0;
    ent_t e;
    int   a    = int'(addr);
    bit   inw  = wr && (a >= BASE) && (a <= LAST);
    int   tile = (a - BASE) / 16;
    int   off  = a % 16;
    if (!en) begin
      m_active = 0;
    end else if (inw) begin
      m_idle = 0;
      if (m_active && tile == m_tile && off == m_next) begin
        m_bytes[off] = data;
        m_next++;
        if (off == 15) begin
          push = 1; e.t = 9'(m_tile); e.h = ref_sig(m_bytes); m_active = 0;
        end
      end else if (off == 0) begin
        m_active = 1; m_tile = tile; m_bytes[0] = data; m_next = 1;
      end else begin
        m_active = 0;
      end
    end else if (m_active) begin
      m_idle++;
      if (m_idle >= TIMEOUT) m_active = 0;
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(e);
      else if (m_drop < 255) m_drop++;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.sig_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check({tag, "_tile"}, 32'(bus.sig_tile_index), 32'(q[0].t));
      check({tag, "_hash"}, 32'(bus.sig_hash), 32'(q[0].h));
    end
    check({tag, "_drop"}, 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic drive(input bit wr, input logic [15:0] addr, input logic [7:0] data,
                       input bit en, input bit ready);
    bus.bus_wr = wr; bus.bus_addr = addr; bus.bus_data = data;
    cfg_enable = en; bus.sig_ready = ready;
  endtask

  task automatic step(input string tag, input bit wr, input logic [15:0] addr,
                      input logic [7:0] data, input bit en, input bit ready);
    @(negedge clk);
    drive(wr, addr, data, en, ready);
    @(posedge clk);
    model_cycle(wr, addr, data, en, ready);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n, input bit ready);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 16'h0000, 8'h00, 1'b1, ready);
  endtask

  task automatic wr_tile(input string tag, input int tile, input int first, input int last,
                         input logic [7:0] data, input bit ready);
    for (int o = first; o <= last; o++)
      step(tag, 1'b1, 16'(BASE + tile * 16 + o), data, 1'b1, ready);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    check("rst_valid", 32'(bus.sig_valid), 32'd0);
    check("rst_tile",  32'(bus.sig_tile_index), 32'd0);
    check("rst_hash",  32'(bus.sig_hash), 32'd0);
    check("rst_drop",  32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    bit          inwin;
    logic [8:0]  tile;
    logic [3:0]  off;
  } dec_vec_t;

  dec_vec_t dec_tab [8];

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);
    model_reset();
    do_reset();

    // Window decode table; also confirms out-of-window writes are harmless.
    dec_tab[0] = '{16'h8000, 8'h11, 1'b1, 9'd0,   4'd0};
    dec_tab[1] = '{16'h8001, 8'h22, 1'b1, 9'd0,   4'd1};
    dec_tab[2] = '{16'h7FFF, 8'h33, 1'b0, 9'd0,   4'd0};
    dec_tab[3] = '{16'h9800, 8'h44, 1'b0, 9'd0,   4'd0};
    dec_tab[4] = '{16'h8002, 8'h55, 1'b1, 9'd0,   4'd2};
    dec_tab[5] = '{16'h8123, 8'h66, 1'b1, 9'd18,  4'd3};
    dec_tab[6] = '{16'h97FF, 8'h77, 1'b1, 9'd383, 4'd15};
    dec_tab[7] = '{16'h9000, 8'h88, 1'b1, 9'd256, 4'd0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, dec_tab[i].addr, dec_tab[i].data, 1'b1, 1'b1);
      #1;
      if (dec_tab[i].inwin) begin
        check($sformatf("dec%0d_tile", i), 32'(cur_tile_index),  32'(dec_tab[i].tile));
        check($sformatf("dec%0d_off", i),  32'(cur_byte_offset), 32'(dec_tab[i].off));
      end
      @(posedge clk);
      model_cycle(1'b1, dec_tab[i].addr, dec_tab[i].data, 1'b1, 1'b1);
      #1;
      check_outputs($sformatf("dec%0d", i));
    end
    do_reset();

    // Tile 0 all zeros: signature stays 16'hFFFF, valid one edge after byte 15.
    wr_tile("t0", 0, 0, 14, 8'h00, 1'b0);
    check("t0_not_yet", 32'(bus.sig_valid), 32'd0);
    wr_tile("t0", 0, 15, 15, 8'h00, 1'b0);
    check("t0_valid", 32'(bus.sig_valid), 32'd1);
    check("t0_tile",  32'(bus.sig_tile_index), 32'd0);
    check("t0_hash",  32'(bus.sig_hash), 32'hFFFF);
    idle("t0_drain", 3, 1'b1);

    // Last tile in the window.
    wr_tile("t383", 383, 0, 14, 8'h00, 1'b0);
    wr_tile("t383", 383, 15, 15, 8'h01, 1'b0);
    check("t383_tile", 32'(bus.sig_tile_index), 32'd383);
    check("t383_hash", 32'(bus.sig_hash), 32'hFFFE);
    idle("t383_drain", 3, 1'b1);

    // Half of tile 5, then tile 6 restarts and completes.
    wr_tile("abort", 5, 0, 7, 8'hA5, 1'b0);
    wr_tile("abort", 6, 0, 15, 8'h3C, 1'b0);
    check("abort_valid", 32'(bus.sig_valid), 32'd1);
    check("abort_tile",  32'(bus.sig_tile_index), 32'd6);
    idle("abort_pop", 1, 1'b1);
    check("abort_single", 32'(bus.sig_valid), 32'd0);

    // Five tiles with the consumer stalled: four held, one dropped.
    do_reset();
    for (int t = 0; t < 5; t++) wr_tile("full", 10 + t, 0, 15, 8'(t * 7 + 1), 1'b0);
    check("full_drop", 32'(drop_cnt), 32'd1);
    check("full_head", 32'(bus.sig_tile_index), 32'd10);
    idle("full_drain", 4, 1'b1);
    check("full_empty", 32'(bus.sig_valid), 32'd0);

    // Timeout: second half arrives after the partial tile was abandoned.
    wr_tile("tmo", 40, 0, 7, 8'h5A, 1'b1);
    idle("tmo_idle", TIMEOUT, 1'b1);
    wr_tile("tmo", 40, 8, 15, 8'h5A, 1'b1);
    check("tmo_nopush", 32'(bus.sig_valid), 32'd0);

    // Reset in the middle of a tile.
    wr_tile("rstmid", 20, 0, 9, 8'hC3, 1'b0);
    do_reset();
    wr_tile("rstmid", 20, 10, 15, 8'hC3, 1'b0);
    check("rstmid_nopush", 32'(bus.sig_valid), 32'd0);

    // Randomized traffic: mostly in-order tile writes with disruptions.
    begin
      int g_tile = 0, g_off = 0;
      for (int i = 0; i < 4000; i++) begin
        int r = int'($urandom_range(0, 99));
        bit en = ($urandom_range(0, 59) != 0);
        bit rd = ($urandom_range(0, 2) != 0);
        if (r < 70) begin
          step("rnd", 1'b1, 16'(BASE + g_tile * 16 + g_off), 8'($urandom), en, rd);
          g_off++;
          if (g_off == 16 || $urandom_range(0, 40) == 0) begin
            g_off = 0;
            g_tile = int'($urandom_range(0, 383));
          end
        end else if (r < 78) begin
          step("rnd", 1'b1, 16'($urandom), 8'($urandom), en, rd);
        end else begin
          step("rnd", 1'b0, 16'($urandom), 8'($urandom), en, rd);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_tile_snooper.md
VRAM_TILE_SNOOPER -- requirements
Module: vram_tile_snooper

Interface
REQ-001 Parameter TILE_BASE, 16'h8000, first byte address of the tile-data window.
REQ-002 Parameter TILE_END, 16'h97FF, last byte address of the tile-data window.
REQ-003 Parameter FIFO_DEPTH, 4, number of entries in the signature FIFO (power of two).
REQ-004 Parameter TIMEOUT_CYCLES, 1024, idle cycles after which a partial tile is abandoned.
REQ-005 clk  in  1  system clock.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 cfg_enable  in  1  snooping enable.
REQ-008 bus_wr  in  1  one-cycle strobe marking a CPU VRAM write.
REQ-009 bus_addr  in  16  write address.
REQ-010 bus_data  in  8  write data.
REQ-011 sig_valid  out  1  FIFO head holds a completed tile signature.
REQ-012 sig_ready  in  1  consumer (hash lookup) accepts the head.
REQ-013 sig_tile_index  out  9  tile index of the head entry.
REQ-014 sig_hash  out  16  16-bit tile signature of the head entry.
REQ-015 cur_tile_index  out  9  tile index of the in-window write this cycle (combinational decode).
REQ-016 cur_byte_offset  out  4  bus_addr[3:0] of the in-window write this cycle.
REQ-017 drop_cnt  out  8  saturating count of completed tiles lost to FIFO full.

Function
REQ-018 In-window write SHALL be: bus_wr=1 and TILE_BASE<=bus_addr<=TILE_END; tile index = (bus_addr-TILE_BASE)>>4, range 0..383.
REQ-019 Out-of-window writes SHALL be ignored and SHALL NOT disturb the assembly in progress.
REQ-020 The FSM SHALL have two states, IDLE and COLLECT.
REQ-021 IDLE: an in-window write with offset 0 SHALL latch the tile index, set expected offset to 1, set hash=H(16'hFFFF,data), and go to COLLECT.
REQ-022 IDLE: an in-window write with a nonzero offset SHALL be ignored.
REQ-023 Hash step SHALL be H(h,d) = {h[10:0],h[15:11]} ^ {8'h00,d}, applied in offset order 0..15.
REQ-024 COLLECT: an in-window write to the latched tile at the expected offset SHALL update the hash and increment the expected offset.
REQ-025 COLLECT: the write at offset 15 SHALL push {tile,final hash} to the FIFO and return to IDLE.
REQ-026 COLLECT: any other in-window write SHALL abort the partial tile; if that write has offset 0 it SHALL restart per REQ-021 in the same cycle, else the FSM goes to IDLE.
REQ-027 COLLECT: TIMEOUT_CYCLES consecutive cycles without an in-window write SHALL abort to IDLE without a push; the idle counter clears on every in-window write.
REQ-028 A push SHALL be accepted when FIFO count<FIFO_DEPTH, or when it is full and a pop occurs in the same cycle; otherwise the entry is dropped and drop_cnt increments, saturating at 255.
REQ-029 Pop SHALL occur on sig_valid&&sig_ready; head outputs SHALL stay stable while sig_valid&&!sig_ready.
REQ-030 Latency: a push into an empty FIFO SHALL raise sig_valid on the next clock edge.
REQ-031 cfg_enable=0 SHALL force IDLE, discard any partial tile, and block pushes; the FIFO SHALL keep draining.

Reset
REQ-032 Reset SHALL set state=IDLE and clear the hash, expected offset, idle counter, FIFO pointers/count and drop_cnt; sig_valid=0, sig_tile_index=0, sig_hash=0.
REQ-033 Reset asserted mid-tile SHALL discard the partial tile; no push occurs.

Structure
REQ-034 Package xlate_pkg SHALL hold the TILE_BASE/TILE_END defaults, the tile_sig_t struct {tile_index[8:0], hash[15:0]} and the snoop state enum.
REQ-035 The FIFO SHALL be a sub-module, tile_sig_fifo, parameterised by depth and carrying tile_sig_t.

Verification
REQ-036 Bench case: 16 sequential writes of 8'h00 to 16'h8000..16'h800F -> one entry, tile 0, hash 16'hFFFF, with sig_valid high one cycle after the last write.
REQ-037 Bench case: tile at 16'h97F0 with 8'h00 at offsets 0..14 and 8'h01 at offset 15 -> tile 383, hash 16'hFFFE.
REQ-038 Bench case: offsets 0..7 of tile 5, then offset 0 of tile 6 plus its 15 remaining bytes -> exactly one entry, tile 6.
REQ-039 Bench case: sig_ready=0 while 5 tiles complete -> 4 entries held and drop_cnt=1; raise sig_ready -> 4 pops in order.
REQ-040 Bench case: half a tile, then 1024 idle cycles, then offsets 8..15 -> no push.
REQ-041 Bench case: rst_n pulsed low after offset 9 -> outputs at reset values and no entry appears afterwards.
